dec_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 decoded resource among 8 requesters.
- Picks one requester, holds the grant until release or timeout, then rotates priority.
- Drives the 3-bit select of the existing decoder datapath and exposes the decoded one-hot grant.
- Sits between the requester lanes and the shared decoder-selected resource.

---
 rtl/dec_rr_arbiter_pkg.sv | 18 +
 rtl/dec_rr_arbiter_dec3to8.sv | 16 +
 rtl/dec_rr_arbiter.sv | 97 +++++++++
 tb/tb_dec_rr_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dec_rr_arbiter_pkg.sv
// Shared constants for the decoded round-robin arbiter: FSM encodings,
// default sizing and the hold-counter width helper.
package dec_rr_arbiter_pkg;

    localparam int N_DEF        = 8;
    localparam int IDXW_DEF     = 3;
    localparam int MAX_HOLD_DEF = 15;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Hold counter must reach MAX_HOLD exactly; a disabled timeout still
    // needs a legal 1-bit vector.
    function automatic int hcnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/dec_rr_arbiter_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; output is all zero
// when disabled.
module dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter sharing one decoder-selected resource among 8 lanes;
// holds a grant until done, abandon or hold timeout, then rotates priority.
module dec_rr_arbiter
    import dec_rr_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDXW     = IDXW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    output logic [IDXW-1:0] gidx,
    output logic [N-1:0]    grant,
    output logic            gvalid,
    output logic            timeout
);

    localparam int            HW       = hcnt_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam bit            TO_EN    = (MAX_HOLD != 0);

    logic [0:0]      state;
    logic [IDXW-1:0] ptr;
    logic [HW-1:0]   hcnt;

    logic            found;
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] idx;

    logic rel_done;
    logic rel_abandon;
    logic rel_to;
    logic release_now;

    // Scan from the farthest offset down to ptr so the nearest set lane
    // in circular order is the last one written and therefore wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + IDXW'(i);
            if (req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign rel_done    = done[gidx];
    assign rel_abandon = ~req[gidx];
    assign rel_to      = TO_EN && (hcnt == HOLD_LIM);
    assign release_now = rel_done | rel_abandon | rel_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gidx    <= '0;
            gvalid  <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            hcnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gidx   <= pick;
                        gvalid <= 1'b1;
                        hcnt   <= HW'(1);
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gvalid  <= 1'b0;
                        ptr     <= gidx + 1'b1;
                        state   <= ST_IDLE;
                        // A normal release or abandon outranks the timeout.
                        timeout <= ~rel_done & ~rel_abandon;
                    end else if (TO_EN && (hcnt != HOLD_LIM)) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    dec3to8 u_dec (
        .sel (gidx),
        .en  (gvalid),
        .y   (grant)
    );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Table-driven, scoreboarded bench for dec_rr_arbiter.
`timescale 1ns/1ps
module tb_dec_rr_arbiter;
    import dec_rr_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic [2:0] gidx;
    logic [7:0] grant;
    logic       gvalid;
    logic       timeout;

    int total  = 0;
    int passed = 0;

    typedef struct {
        string      name;
        logic [7:0] req;
        logic [7:0] done;
        bit         rst_before;
        logic [2:0] gidx;
        logic [7:0] grant;
        logic       gvalid;
        logic       timeout;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    dec_rr_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gidx    (gidx),
        .grant   (grant),
        .gvalid  (gvalid),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running need finished");
        $fatal(1);
    end

    function automatic vec_t mk(input string nm, input logic [7:0] r, input logic [7:0] d,
                                input logic [2:0] gi, input logic gv, input logic to,
                                input bit rb);
        vec_t v;
        v.name       = nm;
        v.req        = r;
        v.done       = d;
        v.rst_before = rb;
        v.gidx       = gi;
        v.grant      = gv ? (8'h01 << gi) : 8'h00;
        v.gvalid     = gv;
        v.timeout    = to;
        return v;
    endfunction

    task automatic add(input string nm, input logic [7:0] r, input logic [7:0] d,
                       input logic [2:0] gi, input logic gv, input logic to, input bit rb);
        tbl.push_back(mk(nm, r, d, gi, gv, to, rb));
    endtask

    task automatic check(input string nm, input logic [2:0] gi, input logic [7:0] gr,
                         input logic gv, input logic to);
        total++;
        if (gidx !== gi || grant !== gr || gvalid !== gv || timeout !== to) begin
            $display("FAIL %s: got gidx=%0d grant=%h gvalid=%b timeout=%b, need gidx=%0d grant=%h gvalid=%b timeout=%b",
                     nm, gidx, grant, gvalid, timeout, gi, gr, gv, to);
        end else begin
            passed++;
        end
    endtask

    // Drive one vector at the falling edge, score it after the next rising edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        if (v.rst_before) begin
            rst = 1'b1;
            #1;
            check("reset_pulse", 3'd0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            rst = 1'b0;
        end
        req  = v.req;
        done = v.done;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.gidx, e.grant, e.gvalid, e.timeout);
    endtask

    initial begin
        int lane;
        rst  = 1'b1;
        req  = 8'h00;
        done = 8'h00;

        // Reset then idle
        for (int i = 0; i < 10; i++) add("idle_after_reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Single request on lane 3, released by done on the 4th grant cycle
        add("single_grant", 8'h08, 8'h00, 3'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add("single_hold", 8'h08, 8'h00, 3'd3, 1'b1, 1'b0, 1'b0);
        add("single_done", 8'h08, 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
        add("single_idle", 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
        add("ptr_is_4", 8'h18, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0);
        add("ptr4_rel", 8'h18, 8'h10, 3'd4, 1'b0, 1'b0, 1'b0);
        add("ptr4_idle", 8'h00, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0);

        // Rotation and wrap from a fresh reset: lanes 0..7 then 0 again
        for (int k = 0; k < 9; k++) begin
            lane = k % 8;
            add("rot_grant", 8'hFF, 8'h00, 3'(lane), 1'b1, 1'b0, (k == 0));
            add("rot_hold", 8'hFF, 8'h00, 3'(lane), 1'b1, 1'b0, 1'b0);
            add("rot_done", 8'hFF, 8'(1 << lane), 3'(lane), 1'b0, 1'b0, 1'b0);
        end
        add("rot_idle", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Timeout on lane 5 after exactly 15 grant cycles, then regrant
        add("to_grant", 8'h20, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) add("to_hold", 8'h20, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);
        add("to_release", 8'h20, 8'h00, 3'd5, 1'b0, 1'b1, 1'b0);
        add("to_regrant", 8'h20, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) add("to_hold2", 8'h20, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);
        add("done_beats_to", 8'h20, 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
        add("to_idle", 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0);

        // Abandon on lane 2 with a stray done[6]; next grant is circular from 3
        add("ab_grant", 8'h04, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0);
        add("ab_ignore_done6", 8'h04, 8'h40, 3'd2, 1'b1, 1'b0, 1'b0);
        add("ab_drop", 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        add("ab_next_lane7", 8'h86, 8'h00, 3'd7, 1'b1, 1'b0, 1'b0);
        add("ab_rel7", 8'h86, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0);
        add("ab_idle", 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);

        #5;
        check("reset_state", 3'd0, 8'h00, 1'b0, 1'b0);
        #15;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset mid-grant: move ptr to 1, grant lane 6, then reset between edges
        apply(mk("mg_lane0", 8'h01, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0));
        apply(mk("mg_rel0", 8'h01, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0));
        apply(mk("mg_lane6", 8'h40, 8'h00, 3'd6, 1'b1, 1'b0, 1'b0));
        apply(mk("mg_hold6", 8'h40, 8'h00, 3'd6, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 3'd0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 3'd0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 8'h41;
        apply(mk("mg_after_ptr0", 8'h41, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0));
        apply(mk("mg_after_rel", 8'h41, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0));
        apply(mk("mg_next_lane6", 8'h41, 8'h00, 3'd6, 1'b1, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
